// File: rtl/seven_seg_reader.sv
// seven_seg_reader: recovers per-digit hex nibbles from a multiplexed active-low seven-segment bus.
module seven_seg_reader #(
  parameter int DIGITS = 4,
  parameter int SETTLE = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   hex,
  output logic [DIGITS-1:0]     valid,
  output logic                  err,
  output logic                  frame
);
  typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;
  state_t state;
  logic [6:0] seg_s1, seg_s2;
  logic [DIGITS-1:0] an_s1, an_s2, an_prev, sel, seen;
  logic [7:0] cnt;
  logic chg, one_hot, multi, sample, legal;
  logic [3:0] nib;
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction
  // The cycle in which the new enable first appears counts as the first stable cycle.
  always_comb begin
    sel = ~an_s2;
    chg = an_s2 != an_prev;
    one_hot = sel != '0 && (sel & (sel - DIGITS'(1))) == '0;
    multi = sel != '0 && !one_hot;
    sample = one_hot && (chg ? SETTLE == 1 : state == S_SETTLE && cnt == 8'(SETTLE - 2));
    {legal, nib} = decode(seg_s2);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      an_s1 <= '1;
      an_s2 <= '1;
      an_prev <= '1;
      state <= S_WAIT;
      cnt <= '0;
      hex <= '0;
      valid <= '0;
      err <= 1'b0;
      frame <= 1'b0;
      seen <= '0;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      an_s1 <= an;
      an_s2 <= an_s1;
      an_prev <= an_s2;
      if (chg) begin
        cnt <= '0;
        state <= sample ? S_HOLD : one_hot ? S_SETTLE : S_WAIT;
      end else if (state == S_SETTLE) begin
        cnt <= cnt + 8'd1;
        if (sample) state <= S_HOLD;
      end
      frame <= !clr && &seen;
      if (clr) begin
        valid <= '0;
        err <= 1'b0;
        seen <= '0;
      end else begin
        seen <= (&seen ? '0 : seen) | (sample ? sel : '0);
        if ((chg && multi) || (sample && !legal)) err <= 1'b1;
        for (int k = 0; k < DIGITS; k++)
          if (sample && sel[k]) begin
            valid[k] <= legal;
            if (legal) hex[4*k +: 4] <= nib;
          end
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_reader.sv
// tb_seven_seg_reader: directed vectors with hand-computed expectations for seven_seg_reader.
module tb_seven_seg_reader;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [6:0] seg = 7'h7F;
  logic [3:0] an = 4'hF;
  logic clr = 1'b0;
  logic [15:0] hex;
  logic [3:0] valid;
  logic err, frame;
  int checks = 0, errors = 0, frames = 0, f0;
  seven_seg_reader #(.DIGITS(4), .SETTLE(3)) dut (
    .clk(clk), .resetn(resetn), .seg(seg), .an(an), .clr(clr),
    .hex(hex), .valid(valid), .err(err), .frame(frame)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (frame) frames++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    seg = s;
    tick(n);
  endtask
  task automatic pulse_clr;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask
  initial begin
    tick(2);
    check("reset_hex", hex, 0);
    check("reset_valid", valid, 0);
    check("reset_err", err, 0);
    check("reset_frame", frame, 0);
    resetn = 1'b1;
    tick(3);
    // digit 0 shows 3; updates exactly 5 edges after an changes
    show(4'b1110, 7'b0000110, 4);
    check("lat_before", valid, 4'b0000);
    tick(1);
    check("lat_valid", valid, 4'b0001);
    check("lat_hex", hex[3:0], 4'h3);
    show(4'b1110, 7'b0000001, 5);
    check("hold_ignores_seg", hex[3:0], 4'h3);
    show(4'b1111, 7'b1111111, 3);
    pulse_clr();
    check("clr_valid", valid, 0);
    // full scan 1, A, d, F
    f0 = frames;
    show(4'b1110, 7'b1001111, 8);
    show(4'b1101, 7'b0001000, 8);
    show(4'b1011, 7'b1000010, 8);
    check("no_frame_early", frames - f0, 0);
    show(4'b0111, 7'b0111000, 8);
    show(4'b1111, 7'b1111111, 4);
    check("scan_hex", hex, 16'hFDA1);
    check("scan_valid", valid, 4'b1111);
    check("scan_frames", frames - f0, 1);
    check("scan_err", err, 0);
    // dwell too short to sample
    pulse_clr();
    f0 = frames;
    show(4'b1101, 7'b1001100, 2);
    show(4'b1111, 7'b1111111, 6);
    check("short_valid", valid, 0);
    check("short_hex", hex, 16'hFDA1);
    check("short_frame", frames - f0, 0);
    // illegal pattern on digit 2, then legal 5 on digit 0
    show(4'b1011, 7'b1111111, 8);
    check("illegal_err", err, 1);
    check("illegal_valid", valid, 0);
    check("illegal_hex_kept", hex[11:8], 4'hD);
    show(4'b1110, 7'b0100100, 8);
    show(4'b1111, 7'b1111111, 5);
    check("err_sticky", err, 1);
    check("valid_after_illegal", valid, 4'b0001);
    check("hex0_five", hex, 16'hFDA5);
    pulse_clr();
    check("clr_err", err, 0);
    check("clr_valid2", valid, 0);
    // two digits enabled at once
    show(4'b1100, 7'b0000000, 8);
    check("multi_err", err, 1);
    check("multi_valid", valid, 0);
    show(4'b1111, 7'b1111111, 3);
    pulse_clr();
    // clr coincident with a legal sample discards it
    show(4'b1110, 7'b0000000, 4);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(3);
    check("clr_wins_valid", valid, 0);
    check("clr_wins_hex", hex[3:0], 4'h5);
    check("clr_wins_err", err, 0);
    // reset mid-settle, then full settle after release
    show(4'b1111, 7'b1111111, 3);
    show(4'b0111, 7'b0000100, 3);
    resetn = 1'b0;
    #1;
    check("mid_reset_hex", hex, 0);
    check("mid_reset_valid", valid, 0);
    check("mid_reset_err", err, 0);
    check("mid_reset_frame", frame, 0);
    tick(2);
    resetn = 1'b1;
    tick(4);
    check("post_reset_before", valid, 0);
    tick(1);
    check("post_reset_valid", valid, 4'b1000);
    check("post_reset_hex", hex, 16'h9000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
